// File: rtl/ioctl_word_packer.sv
// ioctl_word_packer: packs a byte-wide ioctl download stream into 32-bit
// words, queues them in a small FIFO and issues SDRAM write requests.
// Ports: clk, reset_n (sync, active low); ioctl_download/wr/addr/data/index
//   in, ioctl_wait out; sdram_addr/data/we/req out, sdram_ack in;
//   busy and words_written status out.
// Option: define IOCTL_PACKER_BYTESWAP_EN to place lane 0 in data[31:24].
module ioctl_word_packer #(
  parameter int FIFO_DEPTH = 4,
  parameter int ROM_INDEX  = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic [15:0] ioctl_index,
  output logic        ioctl_wait,
  output logic [22:0] sdram_addr,
  output logic [31:0] sdram_data,
  output logic        sdram_we,
  output logic        sdram_req,
  input  logic        sdram_ack,
  output logic        busy,
  output logic [22:0] words_written
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {
    S_IDLE,
    S_REQ
  } state_t;

  logic          r_dl_q;
  logic [3:0]    r_mask;
  logic [31:0]   r_word;
  logic [22:0]   r_waddr;
  logic [22:0]   r_fa [FIFO_DEPTH];
  logic [31:0]   r_fd [FIFO_DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          r_wait;
  state_t        r_state;
  logic [22:0]   r_words;

  state_t        w_state_nxt;
  logic          w_acc;
  logic          w_rise;
  logic          w_fall;
  logic [1:0]    w_lane;
  logic [22:0]   w_waddr;
  logic          w_new;
  logic [31:0]   w_bword;
  logic [31:0]   w_lmask;
  logic [3:0]    w_lsel;
  logic [3:0]    w_base_mask;
  logic [31:0]   w_base_word;
  logic [31:0]   w_fill_word;
  logic [1:0]    w_push_n;
  logic [22:0]   w_pa0;
  logic [31:0]   w_pd0;
  logic [22:0]   w_pa1;
  logic [31:0]   w_pd1;
  logic [3:0]    w_mask_nxt;
  logic [31:0]   w_word_nxt;
  logic [22:0]   w_waddr_nxt;
  logic          w_pop;
  logic [CW-1:0] w_cnt_nxt;

  assign w_acc = ioctl_download & ioctl_wr
               & (ioctl_index == 16'(ROM_INDEX)) & ~r_wait;
  assign w_rise  = ioctl_download & ~r_dl_q;
  assign w_fall  = ~ioctl_download & r_dl_q;
  assign w_lane  = ioctl_addr[1:0];
  assign w_waddr = ioctl_addr[24:2];
  assign w_new   = (r_mask != 4'd0) && (w_waddr != r_waddr);
  assign w_lsel  = 4'd1 << w_lane;

`ifdef IOCTL_PACKER_BYTESWAP_EN
  assign w_bword = {ioctl_data, 24'd0} >> {w_lane, 3'b000};
  assign w_lmask = 32'hFF00_0000 >> {w_lane, 3'b000};
`else
  assign w_bword = {24'd0, ioctl_data} << {w_lane, 3'b000};
  assign w_lmask = 32'h0000_00FF << {w_lane, 3'b000};
`endif

  // An address change that lands on lane 3 yields two pushes in one
  // cycle: the old partial word first, then the freshly completed one.
  // ioctl_wait guarantees two free slots whenever a byte is accepted.
  always_comb begin
    w_push_n    = 2'd0;
    w_pa0       = 23'd0;
    w_pd0       = 32'd0;
    w_pa1       = 23'd0;
    w_pd1       = 32'd0;
    w_base_mask = r_mask;
    w_base_word = r_word;
    w_fill_word = 32'd0;
    w_mask_nxt  = r_mask;
    w_word_nxt  = r_word;
    w_waddr_nxt = r_waddr;
    if (w_acc) begin
      if (w_new) begin
        w_pa0       = r_waddr;
        w_pd0       = r_word;
        w_push_n    = 2'd1;
        w_base_mask = 4'd0;
        w_base_word = 32'd0;
      end
      w_fill_word = (w_base_word & ~w_lmask) | w_bword;
      w_waddr_nxt = w_waddr;
      if (w_lane == 2'd3) begin
        if (w_new) begin
          w_pa1    = w_waddr;
          w_pd1    = w_fill_word;
          w_push_n = 2'd2;
        end else begin
          w_pa0    = w_waddr;
          w_pd0    = w_fill_word;
          w_push_n = 2'd1;
        end
        w_mask_nxt = 4'd0;
        w_word_nxt = 32'd0;
      end else begin
        w_mask_nxt = w_base_mask | w_lsel;
        w_word_nxt = w_fill_word;
      end
    end else if (w_fall && (r_mask != 4'd0)) begin
      w_pa0      = r_waddr;
      w_pd0      = r_word;
      w_push_n   = 2'd1;
      w_mask_nxt = 4'd0;
      w_word_nxt = 32'd0;
    end
  end

  assign w_pop     = (r_state == S_REQ) & sdram_ack;
  assign w_cnt_nxt = r_cnt + CW'(w_push_n) - CW'(w_pop);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (r_cnt != '0) w_state_nxt = S_REQ;
      S_REQ:  if (sdram_ack && (w_cnt_nxt == '0)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push_n != 2'd0) begin
      r_fa[r_wp] <= w_pa0;
      r_fd[r_wp] <= w_pd0;
    end
    if (w_push_n == 2'd2) begin
      r_fa[r_wp + PW'(1)] <= w_pa1;
      r_fd[r_wp + PW'(1)] <= w_pd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_dl_q  <= 1'b0;
      r_mask  <= 4'd0;
      r_word  <= 32'd0;
      r_waddr <= 23'd0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_wait  <= 1'b0;
      r_state <= S_IDLE;
      r_words <= 23'd0;
    end else begin
      r_dl_q  <= ioctl_download;
      r_mask  <= w_mask_nxt;
      r_word  <= w_word_nxt;
      r_waddr <= w_waddr_nxt;
      r_wp    <= r_wp + PW'(w_push_n);
      r_rp    <= r_rp + PW'(w_pop);
      r_cnt   <= w_cnt_nxt;
      r_wait  <= (w_cnt_nxt >= CW'(FIFO_DEPTH - 1));
      r_state <= w_state_nxt;
      if (w_rise) begin
        r_words <= w_pop ? 23'd1 : 23'd0;
      end else if (w_pop) begin
        r_words <= r_words + 23'd1;
      end
    end
  end

  assign ioctl_wait    = r_wait;
  assign sdram_req     = (r_state == S_REQ);
  assign sdram_we      = (r_state == S_REQ);
  assign sdram_addr    = (r_state == S_REQ) ? r_fa[r_rp] : 23'd0;
  assign sdram_data    = (r_state == S_REQ) ? r_fd[r_rp] : 32'd0;
  assign words_written = r_words;
  assign busy = reset_n & (ioctl_download | (r_mask != 4'd0)
              | (r_cnt != '0) | (r_state == S_REQ));

endmodule

// File: tb/tb_ioctl_word_packer.sv
// tb_ioctl_word_packer: directed plus randomized download sessions checked
// against a lane-by-lane word reference model and an SDRAM write monitor.
module tb_ioctl_word_packer;

  localparam int DEPTH = 4;
  localparam int ROM   = 0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic [15:0] ioctl_index;
  logic        ioctl_wait;
  logic [22:0] sdram_addr;
  logic [31:0] sdram_data;
  logic        sdram_we;
  logic        sdram_req;
  logic        sdram_ack;
  logic        busy;
  logic [22:0] words_written;

  always #5 clk = ~clk;

  ioctl_word_packer #(
    .FIFO_DEPTH(DEPTH),
    .ROM_INDEX (ROM)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_data    (ioctl_data),
    .ioctl_index   (ioctl_index),
    .ioctl_wait    (ioctl_wait),
    .sdram_addr    (sdram_addr),
    .sdram_data    (sdram_data),
    .sdram_we      (sdram_we),
    .sdram_req     (sdram_req),
    .sdram_ack     (sdram_ack),
    .busy          (busy),
    .words_written (words_written)
  );

  int n_total = 0;
  int n_pass  = 0;
  bit ack_en  = 1'b0;

  logic [54:0] exp_q[$];
  logic [54:0] got_q[$];

  logic [22:0] m_waddr;
  logic [7:0]  m_b[4];
  bit          m_v[4];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: a word is the set of bytes seen for one word address,
  // closed by lane 3, by an address change, or by the end of download.
  task automatic m_emit();
    logic [31:0] w;
    bit any;
    w = 32'd0;
    any = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (m_v[i]) begin
        any = 1'b1;
`ifdef IOCTL_PACKER_BYTESWAP_EN
        w[8*(3-i) +: 8] = m_b[i];
`else
        w[8*i +: 8] = m_b[i];
`endif
      end
      m_v[i] = 1'b0;
      m_b[i] = 8'd0;
    end
    if (any) exp_q.push_back({m_waddr, w});
  endtask

  task automatic m_byte(input logic [24:0] a, input logic [7:0] d);
    bit any;
    any = m_v[0] | m_v[1] | m_v[2] | m_v[3];
    if (any && (a[24:2] != m_waddr)) m_emit();
    m_waddr = a[24:2];
    m_b[a[1:0]] = d;
    m_v[a[1:0]] = 1'b1;
    if (a[1:0] == 2'd3) m_emit();
  endtask

  initial begin
    sdram_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ack_en && sdram_req && !sdram_ack && ($urandom_range(0, 2) != 0))
        sdram_ack = 1'b1;
      else
        sdram_ack = 1'b0;
    end
  end

  initial begin
    bit pend;
    logic [54:0] held;
    pend = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (reset_n && pend && sdram_req)
        chk("hold", {9'd0, sdram_addr, sdram_data}, {9'd0, held});
      if (reset_n && sdram_req && sdram_ack)
        got_q.push_back({sdram_addr, sdram_data});
      pend = reset_n && sdram_req && !sdram_ack;
      held = {sdram_addr, sdram_data};
    end
  end

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 300) begin
      @(negedge clk);
      ioctl_download = 1'b1;
      ioctl_wr       = 1'b1;
      ioctl_addr     = a;
      ioctl_data     = d;
      ioctl_index    = 16'(ROM);
      ok = !ioctl_wait;
      n++;
    end
    chk("send_accept", {63'd0, ok}, 64'd1);
    if (ok) m_byte(a, d);
  endtask

  task automatic start_dl();
    @(negedge clk);
    ioctl_download = 1'b1;
    ioctl_wr       = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_v[i] = 1'b0;
      m_b[i] = 8'd0;
    end
  endtask

  task automatic end_dl();
    @(negedge clk);
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    m_emit();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    ack_en = 1'b1;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (busy !== 1'b0 && n < 2000);
    chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
    chk({tag, "_nwr"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size())
        chk($sformatf("%s_wr%0d", tag, i), {9'd0, got_q[i]}, {9'd0, exp_q[i]});
    end
    chk({tag, "_words"}, {41'd0, words_written}, 64'(exp_q.size()));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] exp_d;
    logic [24:0] a;
    int nb;
    int r;
    int n;

    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_data     = '0;
    ioctl_index    = 16'(ROM);
    for (int i = 0; i < 4; i++) begin
      m_v[i] = 1'b0;
      m_b[i] = 8'd0;
    end
    m_waddr = '0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_req", {63'd0, sdram_req}, 64'd0);
    chk("rst_we", {63'd0, sdram_we}, 64'd0);
    chk("rst_addr", {41'd0, sdram_addr}, 64'd0);
    chk("rst_data", {32'd0, sdram_data}, 64'd0);
    chk("rst_wait", {63'd0, ioctl_wait}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_words", {41'd0, words_written}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_req", {63'd0, sdram_req}, 64'd0);
    chk("post_data", {32'd0, sdram_data}, 64'd0);
    chk("post_wait", {63'd0, ioctl_wait}, 64'd0);
    chk("post_busy", {63'd0, busy}, 64'd0);

    // Full word, latency of the request
    ack_en = 1'b0;
    start_dl();
    send_byte(25'h000100, 8'h11);
    send_byte(25'h000101, 8'h22);
    send_byte(25'h000102, 8'h33);
    send_byte(25'h000103, 8'h44);
    @(negedge clk);
    ioctl_wr = 1'b0;
    #1;
    chk("lat_n1_req", {63'd0, sdram_req}, 64'd0);
    chk("lat_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    #1;
`ifdef IOCTL_PACKER_BYTESWAP_EN
    exp_d = 32'h11223344;
`else
    exp_d = 32'h44332211;
`endif
    chk("lat_n2_req", {63'd0, sdram_req}, 64'd1);
    chk("lat_n2_we", {63'd0, sdram_we}, 64'd1);
    chk("lat_addr", {41'd0, sdram_addr}, 64'h40);
    chk("lat_data", {32'd0, sdram_data}, {32'd0, exp_d});
    end_dl();
    drain("full");

    // Back-pressure with acks withheld
    ack_en = 1'b0;
    start_dl();
    for (int i = 0; i < 11; i++)
      send_byte(25'h000400 + 25'(i), 8'(8'hA0 + i));
    @(negedge clk);
    ioctl_wr = 1'b0;
    #1;
    chk("wait_occ2", {63'd0, ioctl_wait}, 64'd0);
    send_byte(25'h00040B, 8'hAB);
    @(negedge clk);
    ioctl_wr = 1'b0;
    #1;
    chk("wait_occ3", {63'd0, ioctl_wait}, 64'd1);
    repeat (4) @(negedge clk);
    #1;
    chk("wait_hold", {63'd0, ioctl_wait}, 64'd1);
    chk("wait_req", {63'd0, sdram_req}, 64'd1);
    ack_en = 1'b1;
    for (int i = 12; i < 16; i++)
      send_byte(25'h000400 + 25'(i), 8'(8'hA0 + i));
    end_dl();
    drain("bp");

    // Partial word flushed by the end of download
    start_dl();
    send_byte(25'h000200, 8'hAA);
    send_byte(25'h000201, 8'hBB);
    end_dl();
    drain("tail");

    // Partial word flushed by an address change
    start_dl();
    send_byte(25'h000001, 8'h5C);
    send_byte(25'h000008, 8'h77);
    end_dl();
    drain("jump");

    // Randomized sessions with ignored traffic and random acks
    for (int s = 0; s < 4; s++) begin
      start_dl();
      a = 25'h001000 * 25'(s + 1) + 25'($urandom_range(0, 3));
      nb = $urandom_range(10, 40);
      for (int k = 0; k < nb; k++) begin
        r = $urandom_range(0, 9);
        if (r == 0) begin
          @(negedge clk);
          ioctl_wr    = 1'b1;
          ioctl_index = 16'(ROM + 1);
          ioctl_addr  = 25'($urandom);
          ioctl_data  = 8'($urandom);
        end else if (r == 1) begin
          @(negedge clk);
          ioctl_wr = 1'b0;
        end else begin
          send_byte(a, 8'($urandom));
          if (r >= 8)
            a = {a[24:2] + 23'($urandom_range(2, 9)), 2'($urandom)};
          else
            a = a + 25'd1;
        end
      end
      end_dl();
      @(negedge clk);
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'h000333;
      @(negedge clk);
      ioctl_wr = 1'b0;
      drain($sformatf("rnd%0d", s));
    end

    // Reset in the middle of pending writes
    ack_en = 1'b0;
    start_dl();
    for (int i = 0; i < 8; i++)
      send_byte(25'h000800 + 25'(i), 8'(i * 3 + 1));
    @(negedge clk);
    ioctl_wr = 1'b0;
    n = 0;
    while (sdram_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rq_before", {63'd0, sdram_req}, 64'd1);
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_mid_req", {63'd0, sdram_req}, 64'd0);
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    ack_en  = 1'b1;
    exp_q.delete();
    repeat (20) @(negedge clk);
    #1;
    chk("rst_no_wr", 64'(got_q.size()), 64'd0);
    chk("rst_no_req", {63'd0, sdram_req}, 64'd0);
    chk("rst_words0", {41'd0, words_written}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
